cacheline_burst_adapter: RTL and testbench
==========================================

// Module: cacheline_burst_adapter
// PURPOSE
//  Converts one cache-line transaction (256-bit read fill or writeback) from an
//  I- or D-cache into a 4-beat x 64-bit burst on the cache's port of the memory
//  arbiter. One instance per cache, between the cache and the arbiter.
//  Pulses burst_done so the arbiter can release its grant.
// PARAMETERS
//  LINE_BITS  256  cache line width; must equal BEAT_BITS*BEATS
//  BEAT_BITS  64   memory beat width
//  BEATS      4    beats per line (derived LINE_BITS/BEAT_BITS; 2-bit counter)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  dfp_addr     in   32   cache request address (byte addr; [4:0] ignored)
//  dfp_read     in   1    line fill request, held until dfp_resp
//  dfp_write    in   1    line writeback request, held until dfp_resp
//  dfp_wdata    in   256  writeback line data
//  dfp_rdata    out  256  assembled fill line; beat k at [64k+63:64k]
//  dfp_resp     out  1    1-cycle completion pulse
//  bmem_read    out  1    read request to arbiter
//  bmem_write   out  1    write beat valid to arbiter
//  bmem_addr    out  32   line-aligned address {addr[31:5],5'b0}
//  bmem_wdata   out  64   current write beat
//  bmem_ready   in   1    arbiter accepts request/beat this cycle
//  bmem_rvalid  in   1    read beat valid (already tag-filtered by arbiter)
//  bmem_rdata   in   64   read beat data
//  burst_done   out  1    1-cycle pulse, burst complete (to arbiter)
// BEHAVIOUR
//  - Reset: state=IDLE, beat cnt=0, all outputs 0 (dfp_rdata=0). Reset during
//    any state aborts: partial line dropped, no dfp_resp/burst_done emitted.
//  - All outputs driven from registers/state only; no dfp_*->bmem_* comb path.
//  - IDLE: dfp_write wins if both high. On accept latch line addr, dfp_wdata;
//    cnt=0; -> WR_BURST (write) or RD_REQ (read). No bmem activity in IDLE.
//  - RD_REQ: bmem_read=1, bmem_addr=line addr. Leave when bmem_ready=1 in
//    same cycle -> RD_WAIT; else hold.
//  - RD_WAIT: bmem_read=0. Each bmem_rvalid writes bmem_rdata into slot cnt,
//    cnt++. On beat 3 -> RESP. Beats arrive in order 0..3, gaps allowed.
//  - WR_BURST: bmem_write=1, bmem_addr=line addr, bmem_wdata=wline[cnt].
//    Beat consumed when bmem_ready=1; cnt++; after beat 3 consumed -> RESP.
//    bmem_ready low: hold beat, no advance.
//  - RESP (1 cycle): dfp_resp=1, burst_done=1, -> IDLE. Requests present in
//    RESP are not accepted; earliest next accept is the following IDLE cycle.
//  - Latency, no stalls: read = 1 (RD_REQ) + mem latency + 4 beats + 1;
//    write = 4 + 1 cycles from accept to dfp_resp.
//  - dfp_rdata holds last filled line until the next read's RESP; a write
//    never modifies it.
//  - bmem_rvalid outside RD_WAIT is ignored (no state/data change).
//  - cnt is 2 bits, wraps 3->0 only on leaving the burst.
// TESTING
//  1 Read 0x0000_1234, ready first cycle, beats A0..A3 back-to-back ->
//    bmem_addr=0x0000_1220, one bmem_read cycle, dfp_rdata={A3,A2,A1,A0},
//    dfp_resp & burst_done together once, 1 cycle after A3.
//  2 Write 0x8000_0040, wdata={D3,D2,D1,D0}, ready toggling 1,0,1,1,0,1 ->
//    bmem_wdata sequence D0,D1,D1,D2,D3,D3; exactly 4 beats consumed; resp once.
//  3 dfp_read & dfp_write both high in IDLE -> write burst first; read served
//    only after resp, with cache re-presenting it.
//  4 Stray bmem_rvalid (0xDEAD) in IDLE and WR_BURST -> dfp_rdata unchanged,
//    no resp, cnt unchanged.
//  5 rst asserted after 2 of 4 read beats -> next cycle IDLE, all outputs 0; new
//    read afterwards completes with only its own 4 beats.
//  6 Back-to-back: write then read held high at RESP -> read accepted one cycle
//    after RESP, second burst_done pulse separate from the first.

Source files
------------

// File: rtl/cacheline_burst_adapter.sv
// Splits one cache-line fill/writeback into a BEATS-long burst on the arbiter port.
// Every output decodes from registered state, so nothing on dfp_* reaches bmem_* combinationally.
module cacheline_burst_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int BEATS     = LINE_BITS / BEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [31:0]          bmem_addr,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic                 bmem_rvalid,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  output logic                 burst_done
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BITS / 8) - 32'd1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;
  typedef logic [BEATS-1:0][BEAT_BITS-1:0] line_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  line_t           wline_q, wline_d;
  line_t           fill_q, fill_d;
  line_t           rline_q, rline_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    fill_d  = fill_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // Writeback has priority; the cache keeps the read asserted until served.
        if (dfp_write) begin
          addr_d  = dfp_addr & LINE_MASK;
          wline_d = dfp_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (dfp_read) begin
          addr_d  = dfp_addr & LINE_MASK;
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: if (bmem_ready) state_d = RD_WAIT;
      RD_WAIT: begin
        if (bmem_rvalid) begin
          fill_d[cnt_q] = bmem_rdata;
          cnt_d         = cnt_q + CW'(1);
          // Publish the whole line only once complete; dfp_rdata keeps the old line until then.
          if (cnt_q == LAST) begin
            rline_d = fill_d;
            state_d = RESP;
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      fill_q  <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      fill_q  <= fill_d;
      rline_q <= rline_d;
    end
  end

  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? wline_q[cnt_q] : '0;
  assign dfp_resp   = (state_q == RESP);
  assign burst_done = (state_q == RESP);
  assign dfp_rdata  = rline_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed bench for cacheline_burst_adapter: reads, writes, priority, stray beats, mid-burst reset.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic         bmem_read, bmem_write;
  logic [31:0]  bmem_addr;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_rdata;
  logic         burst_done;

  int checks = 0;
  int failures = 0;

  cacheline_burst_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_addr(bmem_addr),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rvalid(bmem_rvalid),
    .bmem_rdata(bmem_rdata), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0]  a[4], b[4], c[4], e[4], d[4], w[4];
  logic [63:0]  wexp[6];
  logic         rdy[6];
  logic [255:0] line_a, line_b, line_e, line_d, line_w;

  initial begin
    for (int k = 0; k < 4; k++) begin
      a[k] = {32'hA0A0A0A0, 32'(k)};
      b[k] = {32'hB1B1B1B1, 32'(k)};
      c[k] = {32'hC2C2C2C2, 32'(k)};
      e[k] = {32'hE3E3E3E3, 32'(k)};
      d[k] = {32'hD4D4D4D4, 32'(k)};
      w[k] = {32'h57575757, 32'(k)};
    end
    line_a = {a[3], a[2], a[1], a[0]};
    line_b = {b[3], b[2], b[1], b[0]};
    line_e = {e[3], e[2], e[1], e[0]};
    line_d = {d[3], d[2], d[1], d[0]};
    line_w = {w[3], w[2], w[1], w[0]};
    wexp[0] = d[0]; wexp[1] = d[1]; wexp[2] = d[1];
    wexp[3] = d[2]; wexp[4] = d[3]; wexp[5] = d[3];
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b1;
    rdy[3] = 1'b1; rdy[4] = 1'b0; rdy[5] = 1'b1;

    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
    step(); step();
    chk("rst_bmem_read", bmem_read, 0);
    chk("rst_bmem_write", bmem_write, 0);
    chk("rst_bmem_addr", bmem_addr, 0);
    chk("rst_dfp_resp", dfp_resp, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_dfp_rdata", dfp_rdata, 0);
    rst = 1'b0;

    // 1: read fill, ready immediately, beats back-to-back
    dfp_addr = 32'h0000_1234; dfp_read = 1'b1; bmem_ready = 1'b1;
    step();
    chk("t1_req_read", bmem_read, 1);
    chk("t1_req_addr", bmem_addr, 32'h0000_1220);
    chk("t1_req_write", bmem_write, 0);
    step();
    chk("t1_wait_read", bmem_read, 0);
    chk("t1_wait_rdata_old", dfp_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = a[k];
      step();
      if (k < 3) chk("t1_no_early_resp", dfp_resp, 0);
    end
    bmem_rvalid = 1'b0;
    chk("t1_resp", dfp_resp, 1);
    chk("t1_done", burst_done, 1);
    chk("t1_rdata", dfp_rdata, line_a);
    dfp_read = 1'b0;
    step();
    chk("t1_resp_once", dfp_resp, 0);
    chk("t1_done_once", burst_done, 0);
    chk("t1_rdata_hold", dfp_rdata, line_a);

    // 2: writeback with ready toggling
    dfp_addr = 32'h8000_0040; dfp_wdata = line_d; dfp_write = 1'b1;
    step();
    chk("t2_addr", bmem_addr, 32'h8000_0040);
    for (int i = 0; i < 6; i++) begin
      chk("t2_write", bmem_write, 1);
      chk("t2_wdata", bmem_wdata, wexp[i]);
      bmem_ready = rdy[i];
      step();
    end
    chk("t2_resp", dfp_resp, 1);
    chk("t2_write_off", bmem_write, 0);
    chk("t2_rdata_untouched", dfp_rdata, line_a);
    dfp_write = 1'b0; bmem_ready = 1'b1;
    step();
    chk("t2_resp_once", dfp_resp, 0);

    // 3/6: read and write together -> write first, read accepted the cycle after RESP
    dfp_addr = 32'h0000_0100; dfp_wdata = line_w; dfp_read = 1'b1; dfp_write = 1'b1;
    step();
    chk("t3_write_first", bmem_write, 1);
    chk("t3_no_read", bmem_read, 0);
    chk("t3_wdata0", bmem_wdata, w[0]);
    step(); step(); step(); step();
    chk("t3_wr_resp", dfp_resp, 1);
    chk("t3_wr_done", burst_done, 1);
    dfp_write = 1'b0;
    step();
    chk("t3_gap_done", burst_done, 0);
    chk("t3_gap_read", bmem_read, 0);
    step();
    chk("t3_rd_req", bmem_read, 1);
    chk("t3_rd_addr", bmem_addr, 32'h0000_0100);
    step();
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = b[k];
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t3_rd_done", burst_done, 1);
    chk("t3_rd_rdata", dfp_rdata, line_b);
    dfp_read = 1'b0;
    step();

    // 4: stray rvalid in IDLE and during a write burst
    bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD;
    step();
    chk("t4_idle_rdata", dfp_rdata, line_b);
    chk("t4_idle_resp", dfp_resp, 0);
    chk("t4_idle_read", bmem_read, 0);
    dfp_addr = 32'h0000_0200; dfp_wdata = line_d; dfp_write = 1'b1; bmem_ready = 1'b0;
    step(); step(); step();
    chk("t4_wr_hold", bmem_wdata, d[0]);
    chk("t4_wr_noresp", dfp_resp, 0);
    bmem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_wdata", bmem_wdata, d[k]);
      step();
    end
    chk("t4_resp", dfp_resp, 1);
    chk("t4_rdata", dfp_rdata, line_b);
    bmem_rvalid = 1'b0; dfp_write = 1'b0;
    step();

    // 5: reset after two read beats, then a clean read
    dfp_addr = 32'h0000_0300; dfp_read = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = c[k];
      step();
    end
    rst = 1'b1; bmem_rvalid = 1'b0; dfp_read = 1'b0;
    step();
    chk("t5_rst_read", bmem_read, 0);
    chk("t5_rst_write", bmem_write, 0);
    chk("t5_rst_addr", bmem_addr, 0);
    chk("t5_rst_wdata", bmem_wdata, 0);
    chk("t5_rst_resp", dfp_resp, 0);
    chk("t5_rst_done", burst_done, 0);
    chk("t5_rst_rdata", dfp_rdata, 0);
    rst = 1'b0; dfp_addr = 32'h0000_0400; dfp_read = 1'b1;
    step();
    chk("t5_req", bmem_read, 1);
    chk("t5_req_addr", bmem_addr, 32'h0000_0400);
    step();
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = e[k];
      step();
      if (k < 3) chk("t5_no_early_resp", dfp_resp, 0);
    end
    bmem_rvalid = 1'b0;
    chk("t5_resp", dfp_resp, 1);
    chk("t5_rdata", dfp_rdata, line_e);
    dfp_read = 1'b0;
    step();
    chk("t5_resp_once", dfp_resp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
